ps2_frame_receiver: RTL and testbench
=====================================

Name: ps2_frame_receiver

Overview:
- Receives raw PS2_CLK/PS2_DATA from the keyboard connector and delivers decoded key events to MiniAlu.
- Synchronises and glitch-filters both lines, deframes 11-bit PS/2 frames, checks parity and stop bit, and folds E0/F0 prefixes into flags.
- Presents one key event at a time in a holding register with a valid/ack handshake.
- Sits between the board pins (driven by the bench stimulus in simulation) and the MiniAlu keyboard input.

Parameters:
- FILTER_LEN, 4, consecutive Clock cycles a synchronised PS/2 line must hold a new level before the filtered value changes (1..15).
- TIMEOUT_CYCLES, 50000, Clock cycles without a filtered PS2_CLK falling edge, mid-frame, before the frame is aborted.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- PS2_CLK  input  1  raw keyboard clock, asynchronous to Clock.
- PS2_DATA  input  1  raw keyboard data, asynchronous to Clock.
- iKeyAck  input  1  consumer acknowledges the held event.
- oKeyValid  output  1  held event is valid.
- oKeyCode  output  8  scancode of the held event.
- oKeyBreak  output  1  event was preceded by F0 (key release).
- oKeyExt  output  1  event was preceded by E0 (extended key).
- oFrameErr  output  1  one-cycle pulse on a parity, start, stop or timeout error.
- oOverrun  output  1  sticky; an event was dropped because the holding register was full.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; prefix flags cleared; sync and filter registers at 1 (idle line).
- Input conditioning: 2-FF synchroniser on each line, then a per-line filter. Filtered output changes only after FILTER_LEN consecutive cycles at the new synchronised level.
- Edge detect: fall_edge is a one-cycle pulse when filtered clock goes 1->0. Data is sampled from the filtered data line in that same cycle.
- FSM:
  - IDLE: on fall_edge, if data=0 go to DATA with bitcnt=0; if data=1, pulse oFrameErr and stay in IDLE.
  - DATA: on each fall_edge shift the data bit in LSB-first; after 8 bits go to PARITY.
  - PARITY: on fall_edge store the bit, go to STOP.
  - STOP: on fall_edge the frame completes. Valid when stop=1 and XOR(data8, parity)=1 (odd parity). Otherwise pulse oFrameErr and clear both prefix flags. Return to IDLE either way.
- Timeout:
  - The counter resets on every fall_edge and in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES gives: IDLE, one oFrameErr pulse, partial byte discarded, prefixes cleared.
- Decode of a valid byte, in the cycle after the STOP fall_edge:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte forms an event {code, brk_pend, ext_pend} and clears both pend flags.
  - Prefix bytes never produce an event.
- Holding register:
  - If oKeyValid=0, the event loads and oKeyValid=1. Latency: oKeyValid rises exactly 1 cycle after the STOP-bit fall_edge cycle.
  - If oKeyValid=1, the event is dropped, oOverrun is set, and held values are unchanged.
  - iKeyAck while oKeyValid=1 clears oKeyValid next cycle.
  - iKeyAck while oKeyValid=0 is ignored.
  - Same-cycle ack and new event: the new event loads and oKeyValid stays 1; no overrun.
- oOverrun clears only on Reset.
- oKeyCode/oKeyBreak/oKeyExt hold their last values after ack.
- Asynchronous Reset mid-frame: immediate return to the reset state; the next frame must begin with a fresh start bit.

Test Plan:
- Bit-time = 10 Clock cycles per PS/2 clock half-period, with data changed while PS2_CLK is high.
- Frame 0x1C, bits 0,0,0,1,1,1,0,0,0 then parity 0, stop 1 -> oKeyValid=1, oKeyCode=0x1C, oKeyBreak=0, oKeyExt=0, 1 cycle after the final falling edge; iKeyAck -> oKeyValid=0 next cycle.
- Frames F0 (parity 1), 1C -> one event only: 0x1C, oKeyBreak=1, oKeyExt=0. Then E0 (p0), F0 (p1), 75 (p0) -> 0x75, oKeyBreak=1, oKeyExt=1.
- Frame 0x1C with parity 1 -> single oFrameErr pulse, no oKeyValid. A following good 0x1C is received normally.
- 4 data bits, then idle for TIMEOUT_CYCLES+10 -> oFrameErr pulse, FSM in IDLE. Next frame 0x29 (p0) -> oKeyCode=0x29.
- 0x1C then 0x32 (p0) without ack -> oKeyCode stays 0x1C, oOverrun=1. Ack the same cycle as the 0x32 completion (separate run) -> oKeyCode=0x32, oOverrun=0.
- Reset pulse after 5 data bits, then a full 0x1C frame -> exactly one event, 0x1C; 1-cycle glitch on PS2_CLK (< FILTER_LEN) -> no bit sampled.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: conditions the raw lines, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and holds one key event behind a valid/ack handshake.
module ps2_frame_receiver #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       iKeyAck,
    output logic       oKeyValid,
    output logic [7:0] oKeyCode,
    output logic       oKeyBreak,
    output logic       oKeyExt,
    output logic       oFrameErr,
    output logic       oOverrun
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e state_q, state_d;

    // Line index 0 is PS2_CLK, index 1 is PS2_DATA
    logic [1:0] meta_q, sync_q, filt_q;
    logic [3:0] fcnt_q [2];
    logic       clk_prev_q;

    logic [TO_W-1:0] to_cnt_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            ext_pend_q, brk_pend_q;
    logic            frame_err_q;
    logic            valid_q, overrun_q, brk_q, ext_q;
    logic [7:0]      code_q;

    logic fall_edge, bit_in, timeout;
    logic start_err, shift_en, par_en, stop_en;
    logic frame_good, frame_bad, is_e0, is_f0, event_fire;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= {PS2_DATA, PS2_CLK};
            sync_q     <= meta_q;
            clk_prev_q <= filt_q[0];
            // Accept a new level only after FILTER_LEN consecutive cycles at that level
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
                        filt_q[i] <= sync_q[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 4'd1;
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    assign fall_edge = clk_prev_q & ~filt_q[0];
    assign bit_in    = filt_q[1];
    assign timeout   = (state_q != StIdle) && !fall_edge &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (fall_edge && !bit_in) state_d = StData;
            StData:   if (fall_edge && bitcnt_q == 3'd7) state_d = StParity;
            StParity: if (fall_edge) state_d = StStop;
            StStop:   if (fall_edge) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout) state_d = StIdle;
    end

    always_comb begin
        start_err = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        unique case (state_q)
            StIdle:   start_err = fall_edge & bit_in;
            StData:   shift_en  = fall_edge;
            StParity: par_en    = fall_edge;
            StStop:   stop_en   = fall_edge;
            default:  ;
        endcase
    end

    assign frame_good = stop_en & bit_in & (^{shift_q, parity_q});
    assign frame_bad  = stop_en & ~frame_good;
    assign is_e0      = (shift_q == 8'hE0);
    assign is_f0      = (shift_q == 8'hF0);
    assign event_fire = frame_good & ~is_e0 & ~is_f0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            to_cnt_q    <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            code_q      <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            if (state_q == StIdle || fall_edge) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (state_q == StIdle) begin
                bitcnt_q <= '0;
            end else if (shift_en) begin
                bitcnt_q <= bitcnt_q + 3'd1;
            end

            if (timeout) begin
                shift_q <= '0;
            end else if (shift_en) begin
                shift_q <= {bit_in, shift_q[7:1]};
            end

            if (par_en) parity_q <= bit_in;

            if (frame_bad || timeout) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (frame_good) begin
                if (is_e0) begin
                    ext_pend_q <= 1'b1;
                end else if (is_f0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                end
            end

            frame_err_q <= start_err | frame_bad | timeout;

            // A same-cycle ack frees the holding register for the incoming event
            if (event_fire) begin
                if (!valid_q || iKeyAck) begin
                    valid_q <= 1'b1;
                    code_q  <= shift_q;
                    brk_q   <= brk_pend_q;
                    ext_q   <= ext_pend_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (iKeyAck) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign oKeyValid = valid_q;
    assign oKeyCode  = code_q;
    assign oKeyBreak = brk_q;
    assign oKeyExt   = ext_q;
    assign oFrameErr = frame_err_q;
    assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: drives PS/2 frames at 10 clocks per half-period
// and checks events, prefixes, errors, overrun, latency and filtering.
module tb_ps2_frame_receiver;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 300;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       iKeyAck = 1'b0;
    logic       oKeyValid;
    logic [7:0] oKeyCode;
    logic       oKeyBreak, oKeyExt, oFrameErr, oOverrun;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int ev_cnt = 0;
    int err_base, ev_base;
    logic valid_prev = 1'b0;

    ps2_frame_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .iKeyAck   (iKeyAck),
        .oKeyValid (oKeyValid),
        .oKeyCode  (oKeyCode),
        .oKeyBreak (oKeyBreak),
        .oKeyExt   (oKeyExt),
        .oFrameErr (oFrameErr),
        .oOverrun  (oOverrun)
    );

    always #5 Clock = ~Clock;

    // Count error pulses and rising edges of oKeyValid
    always @(posedge Clock) begin
        if (oFrameErr) err_cnt++;
        if (oKeyValid && !valid_prev) ev_cnt++;
        valid_prev = oKeyValid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with PS2_CLK high; returns at a negedge with PS2_CLK high
    task automatic send_bit(input logic b);
        PS2_DATA = b;
        repeat (10) @(negedge Clock);
        PS2_CLK = 1'b0;
        repeat (10) @(negedge Clock);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] code, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par);
        send_head(code, par);
        send_bit(1'b1);
        repeat (10) @(negedge Clock);
    endtask

    task automatic ack;
        iKeyAck = 1'b1;
        @(negedge Clock);
        iKeyAck = 1'b0;
        check("ack_clears_valid", oKeyValid, 1'b0);
    endtask

    initial begin
        @(negedge Clock);
        repeat (3) @(negedge Clock);
        check("rst_valid", oKeyValid, 1'b0);
        check("rst_code", oKeyCode, 8'h00);
        check("rst_flags", {oKeyBreak, oKeyExt, oFrameErr, oOverrun}, 4'b0000);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);

        // 0x1C with exact latency from the stop-bit falling edge
        send_head(8'h1C, 1'b0);
        PS2_DATA = 1'b1;
        repeat (10) @(negedge Clock);
        PS2_CLK = 1'b0;
        repeat (6) @(posedge Clock);
        #1 check("lat_early", oKeyValid, 1'b0);
        @(posedge Clock);
        #1 check("lat_valid", oKeyValid, 1'b1);
        check("f1c_code", oKeyCode, 8'h1C);
        check("f1c_flags", {oKeyBreak, oKeyExt}, 2'b00);
        repeat (3) @(negedge Clock);
        PS2_CLK = 1'b1;
        repeat (10) @(negedge Clock);
        ack();
        check("hold_after_ack", oKeyCode, 8'h1C);
        check("no_err_yet", err_cnt, 0);

        // Break prefix
        send_frame(8'hF0, 1'b1);
        check("prefix_no_event", oKeyValid, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("brk_valid", oKeyValid, 1'b1);
        check("brk_code", oKeyCode, 8'h1C);
        check("brk_flags", {oKeyBreak, oKeyExt}, 2'b10);
        ack();

        // Extended break
        ev_base = ev_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b0);
        check("ext_code", oKeyCode, 8'h75);
        check("ext_flags", {oKeyBreak, oKeyExt}, 2'b11);
        check("ext_one_event", ev_cnt - ev_base, 1);
        ack();

        // Parity error, then recovery
        err_base = err_cnt;
        send_frame(8'h1C, 1'b1);
        check("par_err_pulse", err_cnt - err_base, 1);
        check("par_no_valid", oKeyValid, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("par_recover", {oKeyValid, oKeyCode}, {1'b1, 8'h1C});
        ack();

        // An error frame clears a pending break prefix
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        check("err_clears_prefix", {oKeyValid, oKeyBreak, oKeyExt}, 3'b100);
        ack();

        // Timeout mid-frame
        err_base = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TIMEOUT_CYCLES + 10) @(negedge Clock);
        check("timeout_pulse", err_cnt - err_base, 1);
        check("timeout_no_valid", oKeyValid, 1'b0);
        PS2_DATA = 1'b1;
        send_frame(8'h29, 1'b0);
        check("after_timeout", {oKeyValid, oKeyCode}, {1'b1, 8'h29});
        ack();

        // Overrun without ack
        send_frame(8'h1C, 1'b0);
        send_frame(8'h32, 1'b0);
        check("ovr_code_held", oKeyCode, 8'h1C);
        check("ovr_set", {oKeyValid, oOverrun}, 2'b11);
        ack();
        check("ovr_sticky", oOverrun, 1'b1);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check("ovr_reset", oOverrun, 1'b0);
        repeat (10) @(negedge Clock);

        // Ack in the same cycle the next event completes
        send_frame(8'h1C, 1'b0);
        send_head(8'h32, 1'b0);
        PS2_DATA = 1'b1;
        repeat (10) @(negedge Clock);
        PS2_CLK = 1'b0;
        repeat (6) @(negedge Clock);
        iKeyAck = 1'b1;
        @(negedge Clock);
        iKeyAck = 1'b0;
        repeat (3) @(negedge Clock);
        PS2_CLK = 1'b1;
        repeat (10) @(negedge Clock);
        check("same_cycle_code", {oKeyValid, oKeyCode}, {1'b1, 8'h32});
        check("same_cycle_no_ovr", oOverrun, 1'b0);
        ack();

        // Reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        PS2_DATA = 1'b1;
        repeat (10) @(negedge Clock);
        err_base = err_cnt;
        ev_base = ev_cnt;
        send_frame(8'h1C, 1'b0);
        check("midrst_code", {oKeyValid, oKeyCode}, {1'b1, 8'h1C});
        check("midrst_one_event", ev_cnt - ev_base, 1);
        check("midrst_no_err", err_cnt - err_base, 0);
        ack();

        // One-cycle clock glitch with data low must not look like a start bit
        PS2_DATA = 1'b0;
        repeat (10) @(negedge Clock);
        PS2_CLK = 1'b0;
        @(negedge Clock);
        PS2_CLK = 1'b1;
        repeat (20) @(negedge Clock);
        PS2_DATA = 1'b1;
        repeat (10) @(negedge Clock);
        err_base = err_cnt;
        send_frame(8'h29, 1'b0);
        check("glitch_code", {oKeyValid, oKeyCode}, {1'b1, 8'h29});
        check("glitch_no_err", err_cnt - err_base, 0);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
